rv_decode_stage: RTL

- Registered, handshaked instruction-decode stage for the RV32I core.
- Sits between fetch and register-file/control and replaces the purely combinational decoder.
- Adds full sign-extended immediate generation for all RV32I formats (I/S/B/U/J, JALR), illegal-instruction detection, a 2-entry elastic buffer with valid/ready backpressure, flush, and a saturating illegal-instruction counter.

---
 rtl/decode_pkg.sv | 67 ++++++
 rtl/rv_decode_comb.sv | 107 ++++++++++
 rtl/rv_decode_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared RV32I decode types: opcodes, instruction/immediate classes and the
// decoded payload carried through the decode stage buffer.
package decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        IT_ILLEGAL = 4'b0000,
        IT_LOAD    = 4'b0001,
        IT_STORE   = 4'b0010,
        IT_R       = 4'b0011,
        IT_OP_IMM  = 4'b0100,
        IT_BRANCH  = 4'b0101,
        IT_JAL     = 4'b0110,
        IT_LUI     = 4'b0111,
        IT_AUIPC   = 4'b1000,
        IT_JALR    = 4'b1001,
        IT_FENCE   = 4'b1010,
        IT_SYSTEM  = 4'b1011
    } inst_type_e;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_R    = 3'b010,
        IMM_B    = 3'b011,
        IMM_J    = 3'b100,
        IMM_U    = 3'b101,
        IMM_NONE = 3'b111
    } imm_type_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_e;

    typedef struct packed {
        logic [6:0]  opcode;
        inst_type_e  inst_type;
        imm_type_e   imm_type;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] imm;
        logic        illegal;
    } decoded_t;

    // func7 must be 0, or 0100000 only for the SUB/SRA/SRAI encodings (func3 000/101)
    function automatic logic func7_ok(input logic [6:0] f7, input logic [2:0] f3);
        return (f7 == 7'b0000000) ||
               ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
    endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Pure combinational RV32I decoder: raw instruction word to decoded_t,
// with sign-extended immediates and illegal-instruction detection.
module rv_decode_comb
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    dec
);

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        legal;
    decoded_t    d;

    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        d        = '0;
        d.opcode = instr[6:0];
        legal    = 1'b1;
        if (instr[1:0] != 2'b11) begin
            legal = 1'b0;
        end else begin
            unique case (instr[6:0])
                OPC_OP: begin
                    d.inst_type = IT_R;     d.imm_type = IMM_R;
                    d.rd = instr[11:7];     d.rs1 = instr[19:15]; d.rs2 = instr[24:20];
                    d.func3 = f3;           d.func7 = f7;
                    legal = func7_ok(f7, f3);
                end
                OPC_OP_IMM: begin
                    d.inst_type = IT_OP_IMM; d.imm_type = IMM_I;
                    d.rd = instr[11:7];      d.rs1 = instr[19:15];
                    d.func3 = f3;            d.imm = imm_i;
                    if (f3 == 3'b001) begin
                        d.func7 = f7;
                        legal   = (f7 == 7'b0000000);
                    end else if (f3 == 3'b101) begin
                        d.func7 = f7;
                        legal   = func7_ok(f7, f3);
                    end
                end
                OPC_LOAD: begin
                    d.inst_type = IT_LOAD;  d.imm_type = IMM_I;
                    d.rd = instr[11:7];     d.rs1 = instr[19:15];
                    d.func3 = f3;           d.imm = imm_i;
                    legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
                end
                OPC_STORE: begin
                    d.inst_type = IT_STORE; d.imm_type = IMM_S;
                    d.rs1 = instr[19:15];   d.rs2 = instr[24:20];
                    d.func3 = f3;           d.imm = imm_s;
                    legal = (f3 <= 3'b010);
                end
                OPC_BRANCH: begin
                    d.inst_type = IT_BRANCH; d.imm_type = IMM_B;
                    d.rs1 = instr[19:15];    d.rs2 = instr[24:20];
                    d.func3 = f3;            d.imm = imm_b;
                    legal = !(f3 == 3'b010 || f3 == 3'b011);
                end
                OPC_JAL: begin
                    d.inst_type = IT_JAL;   d.imm_type = IMM_J;
                    d.rd = instr[11:7];     d.imm = imm_j;
                end
                OPC_JALR: begin
                    d.inst_type = IT_JALR;  d.imm_type = IMM_I;
                    d.rd = instr[11:7];     d.rs1 = instr[19:15];
                    d.func3 = f3;           d.imm = imm_i;
                    legal = (f3 == 3'b000);
                end
                OPC_LUI: begin
                    d.inst_type = IT_LUI;   d.imm_type = IMM_U;
                    d.rd = instr[11:7];     d.imm = imm_u;
                end
                OPC_AUIPC: begin
                    d.inst_type = IT_AUIPC; d.imm_type = IMM_U;
                    d.rd = instr[11:7];     d.imm = imm_u;
                end
                OPC_FENCE, OPC_SYSTEM: begin
                    d.inst_type = (instr[6:0] == OPC_FENCE) ? IT_FENCE : IT_SYSTEM;
                    d.imm_type = IMM_I;
                    d.rd = instr[11:7];     d.rs1 = instr[19:15];
                    d.func3 = f3;           d.imm = imm_i;
                end
                default: legal = 1'b0;
            endcase
        end

        // Illegal entries keep only the opcode; every other field reads as zero
        if (!legal) begin
            d           = '0;
            d.opcode    = instr[6:0];
            d.inst_type = IT_ILLEGAL;
            d.imm_type  = IMM_NONE;
            d.illegal   = 1'b1;
        end
        dec = d;
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered, handshaked RV32I decode stage: decodes on the input side and
// holds up to two decoded entries in an order-preserving elastic buffer.
module rv_decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CNT_W   = 8,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [3:0]       out_inst_type,
    output logic [2:0]       out_imm_type,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_func3,
    output logic [6:0]       out_func7,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    buf_state_e      state_q, state_d;
    decoded_t        main_q, main_d, skid_q, skid_d, in_dec;
    logic [XLEN-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            acc, drn;

    rv_decode_comb u_dec (
        .instr (in_instr),
        .dec   (in_dec)
    );

    assign out_valid = (state_q != BUF_EMPTY);
    assign in_ready  = SKID_EN ? (state_q != BUF_TWO) : (!out_valid || out_ready);
    assign acc       = in_valid && in_ready;
    assign drn       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= BUF_EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            main_pc_q <= '0;
            skid_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            main_pc_q <= main_pc_d;
            skid_pc_q <= skid_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        main_pc_d = main_pc_q;
        skid_pc_d = skid_pc_q;
        cnt_d     = cnt_q;
        if (flush) begin
            state_d   = BUF_EMPTY;
            main_d    = '0;
            skid_d    = '0;
            main_pc_d = '0;
            skid_pc_d = '0;
        end else begin
            if (acc && in_dec.illegal && (cnt_q != '1))
                cnt_d = cnt_q + CNT_W'(1);
            unique case (state_q)
                BUF_EMPTY: begin
                    if (acc) begin
                        main_d    = in_dec;
                        main_pc_d = in_pc;
                        state_d   = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    // Without SKID_EN, in_ready already implies drain whenever we accept here
                    if (acc && drn) begin
                        main_d    = in_dec;
                        main_pc_d = in_pc;
                    end else if (acc) begin
                        skid_d    = in_dec;
                        skid_pc_d = in_pc;
                        state_d   = BUF_TWO;
                    end else if (drn) begin
                        state_d   = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (drn) begin
                        main_d    = skid_q;
                        main_pc_d = skid_pc_q;
                        state_d   = BUF_ONE;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    assign out_pc        = main_pc_q;
    assign out_opcode    = main_q.opcode;
    assign out_inst_type = main_q.inst_type;
    assign out_imm_type  = main_q.imm_type;
    assign out_rd        = main_q.rd;
    assign out_rs1       = main_q.rs1;
    assign out_rs2       = main_q.rs2;
    assign out_func3     = main_q.func3;
    assign out_func7     = main_q.func7;
    assign out_imm       = main_q.imm;
    assign out_illegal   = main_q.illegal;
    assign illegal_count = cnt_q;

endmodule
